fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port inst_req, output, 1, instruction fetch request valid.
REQ-005 SHALL have port inst_addr, output, 32, fetch address, equal to the current PC.
REQ-006 SHALL have port inst_addr_ok, input, 1, memory accepted the request this cycle.
REQ-007 SHALL have port inst_data_ok, input, 1, instruction word returned this cycle (data goes to decode directly).
REQ-008 SHALL have port br_valid, input, 1, taken branch/jump resolved; applies after the delay slot.
REQ-009 SHALL have port br_target, input, 32, branch/jump target.
REQ-010 SHALL have port exc_redirect, input, 1, exception/eret flush.
REQ-011 SHALL have port exc_target, input, 32, flush target.
REQ-012 SHALL have port ready_i, input, 1, decode accepts the presented slot.
REQ-013 SHALL have port valid_o, output, 1, slot presented to decode.
REQ-014 SHALL have port pc_o, output, 32, PC of the presented slot.
REQ-015 SHALL have port cancelled_o, output, 1, presented slot is flushed; decode drains its data and discards it.
REQ-016 SHALL have ports exc_o, output, 1; exc_miss_o, output, 1; exccode_o, output, 5, giving the fetch exception for the presented slot.

Function
REQ-017 SHALL implement the FSM S_REQ -> S_WAIT -> S_REQ; S_REQ drives inst_req=1 and inst_addr=pc; inst_addr_ok moves the FSM to S_WAIT.
REQ-018 SHALL, in S_WAIT, drive valid_o=1 and pc_o=pc.
REQ-019 SHALL, in S_WAIT when ready_i=1, load the next PC and return to S_REQ; the next request issues the following cycle (1-cycle bubble minimum).
REQ-020 SHALL compute next PC by priority: pending exception target, else pending branch target (only once the delay slot has been accepted), else pc+4; wrap modulo 2^32.
REQ-021 SHALL latch br_valid/br_target into a one-entry redirect buffer; a later br_valid before consumption overwrites it.
REQ-022 SHALL apply the buffered branch at the first accept of the slot following the branch slot, so the delay slot executes.
REQ-023 SHALL, on exc_redirect with no outstanding request (S_REQ, no addr_ok same cycle), load exc_target into pc at once and clear the branch buffer.
REQ-024 SHALL, on exc_redirect with a request outstanding, set a cancel flag: cancelled_o=1 until that slot is accepted; the slot is then discarded and pc is loaded with exc_target.
REQ-025 SHALL, when pc[1:0]!=0, issue no request; go straight to S_WAIT with exc_o=1, exccode_o=5'h04 (AdEL), exc_miss_o=0.
REQ-026 SHALL drive exc_miss_o=0 in all cases (reserved for TLB refill).
REQ-027 SHALL give exc_redirect priority over br_valid in the same cycle; the branch is dropped.
REQ-028 SHALL hold inst_addr stable while inst_req=1 and inst_addr_ok=0.
REQ-029 SHALL ignore inst_data_ok for state; ordering is guaranteed by a single outstanding request.

Reset
REQ-030 SHALL, on reset assertion, asynchronously set: pc=RESET_PC; state S_REQ; inst_req=0 during reset, 1 in the first cycle after release; valid_o=0, cancelled_o=0, exc_o=0, exc_miss_o=0, exccode_o=0; pc_o=RESET_PC; branch buffer and cancel flag cleared.
REQ-031 SHALL, on reset mid-request, abandon the outstanding request; the memory side is reset together with this block.

Structure
REQ-032 SHALL take RESET_PC, the exccode constants (AdEL=4) and the state encoding from the shared common header already used by the core stages.
REQ-033 SHALL keep the redirect buffer as the one natural sub-module, fetch_redirect_buf, holding the pending branch and exception target; all other logic stays inline.

Verification
REQ-034 SHALL cover this scenario: reset release, addr_ok immediate, ready_i=1 -> inst_addr BFC00000, BFC00004, BFC00008 on consecutive requests.
REQ-035 SHALL cover this scenario: br_valid target 80001000 while slot BFC00004 is presented -> delay slot BFC00008 fetched, then 80001000.
REQ-036 SHALL cover this scenario: exc_redirect target BFC00380 while waiting on BFC00010 -> cancelled_o=1 until accepted, next inst_addr BFC00380.
REQ-037 SHALL cover this scenario: exc_target 80000002 -> no inst_req; valid_o=1, exc_o=1, exccode_o=4, pc_o 80000002.
REQ-038 SHALL cover this scenario: inst_addr_ok held 0 for 5 cycles -> inst_req and inst_addr stable, valid_o=0.
REQ-039 SHALL cover this scenario: br_valid and exc_redirect in the same cycle -> exc_target wins and the branch buffer is empty.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: reset vector, exception codes and FSM state encoding.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;

    typedef enum logic {
        S_REQ,
        S_WAIT
    } fetch_state_t;

    function automatic logic addr_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_redirect_buf.sv
// One-entry redirect buffer: the pending taken branch and the exception target
// waiting for a cancelled slot to drain.
module fetch_redirect_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        br_arm,
    input  logic        exc_capture,
    input  logic [31:0] exc_target,
    input  logic        accept,
    input  logic        clear_branch,
    output logic        br_pending,
    output logic        br_armed,
    output logic [31:0] br_target_q,
    output logic        exc_pending,
    output logic [31:0] exc_target_q
);

    // A branch is armed once its own slot has been accepted; the next accept
    // (the delay slot) consumes it. A newer branch simply overwrites the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_pending  <= 1'b0;
            br_armed    <= 1'b0;
            br_target_q <= 32'h0;
        end else if (clear_branch) begin
            br_pending <= 1'b0;
            br_armed   <= 1'b0;
        end else if (br_valid) begin
            br_pending  <= 1'b1;
            br_armed    <= br_arm;
            br_target_q <= br_target;
        end else if (accept && br_pending) begin
            if (br_armed) begin
                br_pending <= 1'b0;
                br_armed   <= 1'b0;
            end else begin
                br_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_pending  <= 1'b0;
            exc_target_q <= 32'h0;
        end else if (exc_capture) begin
            exc_pending  <= 1'b1;
            exc_target_q <= exc_target;
        end else if (accept) begin
            exc_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding request, delay-slot aware branch
// redirect, exception flush with slot cancellation and AdEL detection.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  accept_pc;
    logic         accept;
    logic         exc_capture;
    logic         clear_branch;
    logic         br_arm;
    logic         br_pending;
    logic         br_armed;
    logic [31:0]  br_target_q;
    logic         exc_pending;
    logic [31:0]  exc_target_q;
    logic         unused_data_ok;

    // Returned data carries no state here: only one request is ever outstanding.
    assign unused_data_ok = inst_data_ok;

    assign accept       = (state == S_WAIT) && ready_i;
    assign exc_capture  = exc_redirect && ((state == S_REQ) ? inst_addr_ok : !ready_i);
    assign clear_branch = exc_redirect || (accept && exc_pending);
    assign br_arm       = (state == S_REQ) || accept;

    assign inst_req    = (state == S_REQ) && !reset;
    assign inst_addr   = pc;
    assign pc_o        = pc;
    assign cancelled_o = exc_pending;
    assign exc_miss_o  = 1'b0;

    always_comb begin
        accept_pc = pc + 32'd4;
        if (exc_redirect) begin
            accept_pc = exc_target;
        end else if (exc_pending) begin
            accept_pc = exc_target_q;
        end else if (br_pending && br_armed) begin
            accept_pc = br_target_q;
        end
    end

    fetch_redirect_buf u_redirect_buf (
        .clk          (clk),
        .reset        (reset),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .br_arm       (br_arm),
        .exc_capture  (exc_capture),
        .exc_target   (exc_target),
        .accept       (accept),
        .clear_branch (clear_branch),
        .br_pending   (br_pending),
        .br_armed     (br_armed),
        .br_target_q  (br_target_q),
        .exc_pending  (exc_pending),
        .exc_target_q (exc_target_q)
    );

    // A misaligned PC never sits in S_REQ: it goes straight to a presented AdEL slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            valid_o   <= 1'b0;
            exc_o     <= 1'b0;
            exccode_o <= EXC_NONE;
        end else begin
            case (state)
                S_REQ: begin
                    if (inst_addr_ok) begin
                        state     <= S_WAIT;
                        valid_o   <= 1'b1;
                        exc_o     <= 1'b0;
                        exccode_o <= EXC_NONE;
                    end else if (exc_redirect) begin
                        pc <= exc_target;
                        if (addr_misaligned(exc_target)) begin
                            state     <= S_WAIT;
                            valid_o   <= 1'b1;
                            exc_o     <= 1'b1;
                            exccode_o <= EXC_ADEL;
                        end
                    end
                end
                S_WAIT: begin
                    if (ready_i) begin
                        pc <= accept_pc;
                        if (addr_misaligned(accept_pc)) begin
                            state     <= S_WAIT;
                            valid_o   <= 1'b1;
                            exc_o     <= 1'b1;
                            exccode_o <= EXC_ADEL;
                        end else begin
                            state     <= S_REQ;
                            valid_o   <= 1'b0;
                            exc_o     <= 1'b0;
                            exccode_o <= EXC_NONE;
                        end
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard queue of expected fetch
// addresses is filled as redirects are driven and drained as requests appear.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_redirect;
    logic [31:0] exc_target;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        cancelled_o;
    logic        exc_o;
    logic        exc_miss_o;
    logic [4:0]  exccode_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_addr;

    fetch_stage #(.RESET_PC(32'hBFC00000)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .cancelled_o  (cancelled_o),
        .exc_o        (exc_o),
        .exc_miss_o   (exc_miss_o),
        .exccode_o    (exccode_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, compare it with the scoreboard head, then grant it.
    task automatic do_request(input int hold);
        int n;
        n = 0;
        while (inst_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", {31'b0, inst_req}, 32'd1);
        cur_addr = exp_q.pop_front();
        check("inst_addr", inst_addr, cur_addr);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_req", {31'b0, inst_req}, 32'd1);
            check("hold_addr", inst_addr, cur_addr);
            check("hold_valid", {31'b0, valid_o}, 32'd0);
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        check("valid_after_grant", {31'b0, valid_o}, 32'd1);
        check("req_drop", {31'b0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        tick();
        inst_data_ok = 1'b0;
    endtask

    task automatic do_accept(input logic exp_cancel);
        check("slot_valid", {31'b0, valid_o}, 32'd1);
        check("slot_pc", pc_o, cur_addr);
        check("slot_cancel", {31'b0, cancelled_o}, {31'b0, exp_cancel});
        check("slot_exc", {31'b0, exc_o}, 32'd0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("post_accept_valid", {31'b0, valid_o}, 32'd0);
        check("post_accept_cancel", {31'b0, cancelled_o}, 32'd0);
        check("post_accept_req", {31'b0, inst_req}, 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        br_valid     = 1'b0;
        br_target    = 32'h0;
        exc_redirect = 1'b0;
        exc_target   = 32'h0;
        ready_i      = 1'b0;
        tick();
        tick();

        check("rst_req", {31'b0, inst_req}, 32'd0);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_pc", pc_o, 32'hBFC00000);
        check("rst_cancel", {31'b0, cancelled_o}, 32'd0);
        check("rst_exc", {31'b0, exc_o}, 32'd0);
        check("rst_miss", {31'b0, exc_miss_o}, 32'd0);
        check("rst_code", {27'b0, exccode_o}, 32'd0);

        reset = 1'b0;
        #1;
        check("first_req", {31'b0, inst_req}, 32'd1);

        // Sequential fetch, with a branch resolved while slot BFC00004 is presented.
        exp_q.push_back(32'hBFC00000);
        exp_q.push_back(32'hBFC00004);
        do_request(0);
        do_accept(1'b0);
        do_request(0);
        br_valid  = 1'b1;
        br_target = 32'h80001000;
        tick();
        br_valid  = 1'b0;
        do_accept(1'b0);
        exp_q.push_back(32'hBFC00008);
        exp_q.push_back(32'h80001000);
        do_request(0);
        do_accept(1'b0);
        do_request(0);
        do_accept(1'b0);
        check("after_target", inst_addr, 32'h80001004);

        // Flush with nothing outstanding loads the PC immediately.
        exc_redirect = 1'b1;
        exc_target   = 32'hBFC00010;
        tick();
        exc_redirect = 1'b0;
        exp_q.push_back(32'hBFC00010);
        do_request(0);

        // Flush while a slot is outstanding cancels that slot.
        exc_redirect = 1'b1;
        exc_target   = 32'hBFC00380;
        tick();
        exc_redirect = 1'b0;
        check("cancel_set", {31'b0, cancelled_o}, 32'd1);
        tick();
        check("cancel_hold", {31'b0, cancelled_o}, 32'd1);
        do_accept(1'b1);
        exp_q.push_back(32'hBFC00380);
        do_request(5);
        do_accept(1'b0);

        // Branch and flush together: flush wins and the branch is dropped.
        br_valid     = 1'b1;
        br_target    = 32'h80002000;
        exc_redirect = 1'b1;
        exc_target   = 32'h9FC00000;
        tick();
        br_valid     = 1'b0;
        exc_redirect = 1'b0;
        exp_q.push_back(32'h9FC00000);
        exp_q.push_back(32'h9FC00004);
        do_request(0);
        do_accept(1'b0);
        do_request(0);
        do_accept(1'b0);
        check("no_stale_branch", inst_addr, 32'h9FC00008);

        // Misaligned target: no request, AdEL slot presented instead.
        exc_redirect = 1'b1;
        exc_target   = 32'h80000002;
        tick();
        exc_redirect = 1'b0;
        check("adel_req", {31'b0, inst_req}, 32'd0);
        check("adel_valid", {31'b0, valid_o}, 32'd1);
        check("adel_exc", {31'b0, exc_o}, 32'd1);
        check("adel_code", {27'b0, exccode_o}, 32'h4);
        check("adel_miss", {31'b0, exc_miss_o}, 32'd0);
        check("adel_pc", pc_o, 32'h80000002);
        tick();
        tick();
        check("adel_no_req", {31'b0, inst_req}, 32'd0);

        // Reset in the middle of the AdEL slot returns everything to the vector.
        reset = 1'b1;
        #1;
        check("rst2_req", {31'b0, inst_req}, 32'd0);
        check("rst2_valid", {31'b0, valid_o}, 32'd0);
        check("rst2_exc", {31'b0, exc_o}, 32'd0);
        check("rst2_pc", pc_o, 32'hBFC00000);
        tick();
        reset = 1'b0;
        #1;
        check("rst2_first_req", {31'b0, inst_req}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
